alu_unit: RTL

Execution unit on the issue side of the reservation station. It accepts one ready instruction per cycle from the RS (`alu_ena`/`alu_opt`/operands), computes the RV32I integer, jump or branch result, and broadcasts it one cycle later on the ALU CDB channel. That channel is consumed by the RS wake-up logic and by the ROB. A one-entry pending register ensures an op dispatched just before a `rdy` drop is never lost.

---
 rtl/alu_unit_pkg.sv | 55 +++++
 rtl/alu_unit_core.sv | 69 ++++++
 rtl/alu_unit.sv | 94 +++++++++
 3 files changed

// File: rtl/alu_unit_pkg.sv
// Shared widths, operation codes and constants for the ALU execution unit.
// No ports. Imported by alu_core, alu_unit and the testbench.
package alu_unit_pkg;

  localparam int WORD_W    = 32;
  localparam int OPT_W     = 6;
  localparam int ROB_IDX_W = 4;

  typedef logic [WORD_W-1:0]    word_t;
  typedef logic [OPT_W-1:0]     inst_opt_t;
  typedef logic [ROB_IDX_W-1:0] rob_idx_t;

  localparam word_t    ZERO_WORD    = '0;
  localparam rob_idx_t ZERO_ROB_IDX = '0;

  localparam inst_opt_t OPT_NONE  = 6'd0;
  localparam inst_opt_t OPT_LUI   = 6'd1;
  localparam inst_opt_t OPT_AUIPC = 6'd2;
  localparam inst_opt_t OPT_JAL   = 6'd3;
  localparam inst_opt_t OPT_JALR  = 6'd4;
  localparam inst_opt_t OPT_BEQ   = 6'd5;
  localparam inst_opt_t OPT_BNE   = 6'd6;
  localparam inst_opt_t OPT_BLT   = 6'd7;
  localparam inst_opt_t OPT_BGE   = 6'd8;
  localparam inst_opt_t OPT_BLTU  = 6'd9;
  localparam inst_opt_t OPT_BGEU  = 6'd10;
  localparam inst_opt_t OPT_LB    = 6'd11;
  localparam inst_opt_t OPT_LH    = 6'd12;
  localparam inst_opt_t OPT_LW    = 6'd13;
  localparam inst_opt_t OPT_LBU   = 6'd14;
  localparam inst_opt_t OPT_LHU   = 6'd15;
  localparam inst_opt_t OPT_SB    = 6'd16;
  localparam inst_opt_t OPT_SH    = 6'd17;
  localparam inst_opt_t OPT_SW    = 6'd18;
  localparam inst_opt_t OPT_ADDI  = 6'd19;
  localparam inst_opt_t OPT_SLTI  = 6'd20;
  localparam inst_opt_t OPT_SLTIU = 6'd21;
  localparam inst_opt_t OPT_XORI  = 6'd22;
  localparam inst_opt_t OPT_ORI   = 6'd23;
  localparam inst_opt_t OPT_ANDI  = 6'd24;
  localparam inst_opt_t OPT_SLLI  = 6'd25;
  localparam inst_opt_t OPT_SRLI  = 6'd26;
  localparam inst_opt_t OPT_SRAI  = 6'd27;
  localparam inst_opt_t OPT_ADD   = 6'd28;
  localparam inst_opt_t OPT_SUB   = 6'd29;
  localparam inst_opt_t OPT_SLL   = 6'd30;
  localparam inst_opt_t OPT_SLT   = 6'd31;
  localparam inst_opt_t OPT_SLTU  = 6'd32;
  localparam inst_opt_t OPT_XOR   = 6'd33;
  localparam inst_opt_t OPT_SRL   = 6'd34;
  localparam inst_opt_t OPT_SRA   = 6'd35;
  localparam inst_opt_t OPT_OR    = 6'd36;
  localparam inst_opt_t OPT_AND   = 6'd37;

endpackage

// File: rtl/alu_unit_core.sv
// alu_core: purely combinational RV32I integer/jump/branch datapath.
// Ports: opt, val1, val2, imm in; supported, val, br_taken, target out.
// supported=0 for loads, stores, OPT_NONE and unknown codes.
module alu_core
  import alu_unit_pkg::*;
(
  input  logic [OPT_W-1:0]  opt,
  input  logic [WORD_W-1:0] val1,
  input  logic [WORD_W-1:0] val2,
  input  logic [WORD_W-1:0] imm,
  output logic              supported,
  output logic [WORD_W-1:0] val,
  output logic              br_taken,
  output logic [WORD_W-1:0] target
);

  logic signed [WORD_W-1:0] s1, s2, si;

  assign s1 = $signed(val1);
  assign s2 = $signed(val2);
  assign si = $signed(imm);

  always_comb begin
    supported = 1'b1;
    val       = ZERO_WORD;
    br_taken  = 1'b0;
    target    = ZERO_WORD;
    case (opt)
      OPT_ADD:   val = val1 + val2;
      OPT_SUB:   val = val1 - val2;
      OPT_SLL:   val = val1 << val2[4:0];
      OPT_SLT:   val = {31'b0, s1 < s2};
      OPT_SLTU:  val = {31'b0, val1 < val2};
      OPT_XOR:   val = val1 ^ val2;
      OPT_SRL:   val = val1 >> val2[4:0];
      OPT_SRA:   val = $unsigned(s1 >>> val2[4:0]);
      OPT_OR:    val = val1 | val2;
      OPT_AND:   val = val1 & val2;
      OPT_ADDI:  val = val1 + imm;
      OPT_SLTI:  val = {31'b0, s1 < si};
      OPT_SLTIU: val = {31'b0, val1 < imm};
      OPT_XORI:  val = val1 ^ imm;
      OPT_ORI:   val = val1 | imm;
      OPT_ANDI:  val = val1 & imm;
      OPT_SLLI:  val = val1 << imm[4:0];
      OPT_SRLI:  val = val1 >> imm[4:0];
      OPT_SRAI:  val = $unsigned(s1 >>> imm[4:0]);
      OPT_LUI:   val = imm;
      OPT_AUIPC: val = val1 + imm;
      OPT_JAL: begin
        val      = val1 + 32'd4;
        br_taken = 1'b1;
      end
      OPT_JALR: begin
        val      = val2;
        target   = (val1 + imm) & ~32'd1;
        br_taken = 1'b1;
      end
      OPT_BEQ:   br_taken = (val1 == val2);
      OPT_BNE:   br_taken = (val1 != val2);
      OPT_BLT:   br_taken = (s1 < s2);
      OPT_BGE:   br_taken = (s1 >= s2);
      OPT_BLTU:  br_taken = (val1 < val2);
      OPT_BGEU:  br_taken = (val1 >= val2);
      default:   supported = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_unit.sv
// alu_unit: issue-side execution unit. Registers one op per cycle from the RS
// and broadcasts its result on the ALU CDB channel the following cycle.
// Ports: clk, rst (sync, active-high), rdy (stall when low), alu_rb (flush),
// alu_ena/alu_opt/alu_val1/alu_val2/alu_imm/alu_rob_idx (incoming op),
// cdb_alu_valid/src/val/br_taken/target (registered result).
module alu_unit
  import alu_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 alu_rb,
  input  logic                 alu_ena,
  input  logic [OPT_W-1:0]     alu_opt,
  input  logic [WORD_W-1:0]    alu_val1,
  input  logic [WORD_W-1:0]    alu_val2,
  input  logic [WORD_W-1:0]    alu_imm,
  input  logic [ROB_IDX_W-1:0] alu_rob_idx,
  output logic                 cdb_alu_valid,
  output logic [ROB_IDX_W-1:0] cdb_alu_src,
  output logic [WORD_W-1:0]    cdb_alu_val,
  output logic                 cdb_alu_br_taken,
  output logic [WORD_W-1:0]    cdb_alu_target
);

  logic                 pend_valid;
  logic [OPT_W-1:0]     pend_opt;
  logic [WORD_W-1:0]    pend_val1, pend_val2, pend_imm;
  logic [ROB_IDX_W-1:0] pend_rob_idx;

  // A pending op is always older than the incoming one, so it wins the core.
  logic [OPT_W-1:0]     sel_opt;
  logic [WORD_W-1:0]    sel_val1, sel_val2, sel_imm;
  logic [ROB_IDX_W-1:0] sel_rob_idx;
  logic                 sel_valid;

  assign sel_opt     = pend_valid ? pend_opt     : alu_opt;
  assign sel_val1    = pend_valid ? pend_val1    : alu_val1;
  assign sel_val2    = pend_valid ? pend_val2    : alu_val2;
  assign sel_imm     = pend_valid ? pend_imm     : alu_imm;
  assign sel_rob_idx = pend_valid ? pend_rob_idx : alu_rob_idx;
  assign sel_valid   = pend_valid | alu_ena;

  logic              core_sup, core_br;
  logic [WORD_W-1:0] core_val, core_tgt;

  alu_core u_core (
    .opt       (sel_opt),
    .val1      (sel_val1),
    .val2      (sel_val2),
    .imm       (sel_imm),
    .supported (core_sup),
    .val       (core_val),
    .br_taken  (core_br),
    .target    (core_tgt)
  );

  logic fire;
  assign fire = sel_valid & core_sup;

  always_ff @(posedge clk) begin
    if (rst || alu_rb) begin
      cdb_alu_valid    <= 1'b0;
      cdb_alu_src      <= ZERO_ROB_IDX;
      cdb_alu_val      <= ZERO_WORD;
      cdb_alu_br_taken <= 1'b0;
      cdb_alu_target   <= ZERO_WORD;
      pend_valid       <= 1'b0;
    end else if (!rdy) begin
      // Output holds so consumers still see it at the next rdy-high edge.
      if (alu_ena) pend_valid <= 1'b1;
    end else begin
      cdb_alu_valid    <= fire;
      cdb_alu_src      <= fire ? sel_rob_idx : ZERO_ROB_IDX;
      cdb_alu_val      <= fire ? core_val    : ZERO_WORD;
      cdb_alu_br_taken <= fire & core_br;
      cdb_alu_target   <= fire ? core_tgt    : ZERO_WORD;
      // Draining pending while a new op arrives: the new op takes its place.
      if (pend_valid) pend_valid <= alu_ena;
    end
  end

  // Op payload needs no reset; pend_valid qualifies it.
  always_ff @(posedge clk) begin
    if (!rst && !alu_rb && alu_ena && (!rdy || pend_valid)) begin
      pend_opt     <= alu_opt;
      pend_val1    <= alu_val1;
      pend_val2    <= alu_val2;
      pend_imm     <= alu_imm;
      pend_rob_idx <= alu_rob_idx;
    end
  end

endmodule
